// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request instruction fetcher.
//
// Issues one instruction-memory read at a time from the current pc. It buffers
// the returned word for decode and handles branch redirects. A response to a
// request made stale by a redirect is dropped in DRAIN.
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_i         synchronous active-high reset
//   branch_i      redirect request (one cycle per taken branch)
//   target_i      branch target; bits [1:0] ignored
//   imem_req_o    read request, asserted only in ISSUE
//   imem_addr_o   read address (meaningful while imem_req_o=1)
//   imem_valid_i  read response strobe
//   imem_data_i   read response word
//   inst_valid_o  instruction buffer holds a valid instruction
//   inst_o        buffered instruction
//   inst_pc_o     fetch address of the buffered instruction
//   inst_ready_i  decode accepts the buffered instruction
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        branch_i,
   input  logic [63:0] target_i,
   output logic        imem_req_o,
   output logic [63:0] imem_addr_o,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_data_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [63:0] inst_pc_o,
   input  logic        inst_ready_i
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StIssue = 3'd1;
   localparam logic [2:0] StWait  = 3'd2;
   localparam logic [2:0] StFull  = 3'd3;
   localparam logic [2:0] StDrain = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_q, inst_d;
   logic [63:0] inst_pc_q, inst_pc_d;
   logic [63:0] branch_pc;

   assign branch_pc = {target_i[63:2], 2'b00};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;

      unique case (state_q)
         StIdle:  state_d = StIssue;
         // The request leaves in this cycle; a redirect makes its answer stale.
         StIssue: state_d = branch_i ? StDrain : StWait;
         StWait: begin
            if (branch_i) begin
               // A response landing with the redirect is dropped right here.
               state_d = imem_valid_i ? StIssue : StDrain;
            end else if (imem_valid_i) begin
               state_d      = StFull;
               inst_d       = imem_data_i;
               inst_pc_d    = pc_q;
               inst_valid_d = 1'b1;
               pc_d         = pc_q + 64'd4;
            end
         end
         StFull: begin
            if (branch_i || inst_ready_i) begin
               state_d      = StIssue;
               inst_valid_d = 1'b0;
            end
         end
         StDrain: begin
            if (imem_valid_i) begin
               state_d = StIssue;
            end
         end
         default: state_d = StIdle;
      endcase

      // A redirect overrides any sequential pc update and flushes the buffer.
      if (branch_i) begin
         pc_d         = branch_pc;
         inst_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_q       <= 32'h0;
         inst_pc_q    <= 64'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   assign imem_req_o   = (state_q == StIssue);
   assign imem_addr_o  = pc_q;
   assign inst_valid_o = inst_valid_q;
   assign inst_o       = inst_q;
   assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with hand-computed expectations.
// Instance u_dut uses RESET_PC=0; instance u_dut_w uses RESET_PC=...FFFC so
// that pc wrap-around can be exercised.
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Primary instance signals
   logic        rst, br, iv, rdy;
   logic [63:0] tgt;
   logic [31:0] idata;
   logic        req, ivld;
   logic [63:0] addr, ipc;
   logic [31:0] inst;

   // Wrap instance signals
   logic        rst_w, iv_w, rdy_w;
   logic [31:0] idata_w;
   logic        req_w, ivld_w;
   logic [63:0] addr_w, ipc_w;
   logic [31:0] inst_w;

   fetch_unit #(.RESET_PC(64'h0)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .branch_i     (br),
      .target_i     (tgt),
      .imem_req_o   (req),
      .imem_addr_o  (addr),
      .imem_valid_i (iv),
      .imem_data_i  (idata),
      .inst_valid_o (ivld),
      .inst_o       (inst),
      .inst_pc_o    (ipc),
      .inst_ready_i (rdy)
   );

   fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_w (
      .clk_i        (clk),
      .rst_i        (rst_w),
      .branch_i     (1'b0),
      .target_i     (64'h0),
      .imem_req_o   (req_w),
      .imem_addr_o  (addr_w),
      .imem_valid_i (iv_w),
      .imem_data_i  (idata_w),
      .inst_valid_o (ivld_w),
      .inst_o       (inst_w),
      .inst_pc_o    (ipc_w),
      .inst_ready_i (rdy_w)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; br = 1'b0; iv = 1'b0; rdy = 1'b1; tgt = 64'h0; idata = 32'h0;
      rst_w = 1'b1; iv_w = 1'b0; rdy_w = 1'b1; idata_w = 32'h0;

      // Reset state
      tick();
      check("rst_req", {63'h0, req}, 64'h0);
      check("rst_ivld", {63'h0, ivld}, 64'h0);
      check("rst_inst", {32'h0, inst}, 64'h0);
      check("rst_ipc", ipc, 64'h0);

      // Basic fetch, memory answers one cycle after the request
      rst = 1'b0;
      tick();                                     // IDLE -> ISSUE
      check("f1_req", {63'h0, req}, 64'h1);
      check("f1_addr", addr, 64'h0);
      tick();                                     // ISSUE -> WAIT
      check("f1_wait_req", {63'h0, req}, 64'h0);
      iv = 1'b1; idata = 32'hAAAA_0001;
      tick();                                     // WAIT -> FULL
      iv = 1'b0;
      check("f1_ivld", {63'h0, ivld}, 64'h1);
      check("f1_inst", {32'h0, inst}, 64'h0000_0000_AAAA_0001);
      check("f1_ipc", ipc, 64'h0);
      tick();                                     // FULL -> ISSUE, 3 cycles/instr
      check("f2_req", {63'h0, req}, 64'h1);
      check("f2_addr", addr, 64'h4);
      check("f2_ivld", {63'h0, ivld}, 64'h0);

      // Backpressure: decode stalls for 5 cycles
      tick();                                     // WAIT
      iv = 1'b1; idata = 32'hBBBB_0002;
      tick();                                     // FULL
      iv = 1'b0; rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_ivld", {63'h0, ivld}, 64'h1);
         check("bp_inst", {32'h0, inst}, 64'h0000_0000_BBBB_0002);
         check("bp_ipc", ipc, 64'h4);
         check("bp_req", {63'h0, req}, 64'h0);
         tick();
      end
      check("bp_hold_ivld", {63'h0, ivld}, 64'h1);
      rdy = 1'b1;
      tick();                                     // single transfer -> ISSUE
      check("bp_xfer_ivld", {63'h0, ivld}, 64'h0);
      check("bp_next_addr", addr, 64'h8);

      // Branch in WAIT, stale response two cycles later
      tick();                                     // WAIT
      br = 1'b1; tgt = 64'h1003;
      tick();                                     // -> DRAIN
      br = 1'b0;
      check("bw_drain_req", {63'h0, req}, 64'h0);
      check("bw_drain_ivld", {63'h0, ivld}, 64'h0);
      tick();                                     // DRAIN, nothing yet
      check("bw_drain2_req", {63'h0, req}, 64'h0);
      iv = 1'b1; idata = 32'hCCCC_0003;
      tick();                                     // DRAIN -> ISSUE, response dropped
      iv = 1'b0;
      check("bw_ivld", {63'h0, ivld}, 64'h0);
      check("bw_req", {63'h0, req}, 64'h1);
      check("bw_addr", addr, 64'h1000);

      // Branch coincident with response in WAIT
      tick();                                     // WAIT
      br = 1'b1; tgt = 64'h2000; iv = 1'b1; idata = 32'hDDDD_0004;
      tick();                                     // -> ISSUE
      br = 1'b0; iv = 1'b0;
      check("bv_ivld", {63'h0, ivld}, 64'h0);
      check("bv_req", {63'h0, req}, 64'h1);
      check("bv_addr", addr, 64'h2000);

      // Branch while FULL and stalled flushes the buffer
      tick();                                     // WAIT
      iv = 1'b1; idata = 32'hEEEE_0005;
      tick();                                     // FULL
      iv = 1'b0;
      check("bf_ipc", ipc, 64'h2000);
      br = 1'b1; tgt = 64'h3000; rdy = 1'b0;
      tick();                                     // -> ISSUE
      br = 1'b0; rdy = 1'b1;
      check("bf_ivld", {63'h0, ivld}, 64'h0);
      check("bf_addr", addr, 64'h3000);

      // Branch in ISSUE goes to DRAIN
      br = 1'b1; tgt = 64'h4002;
      tick();                                     // -> DRAIN
      br = 1'b0;
      check("bi_req", {63'h0, req}, 64'h0);
      iv = 1'b1;
      tick();                                     // -> ISSUE
      iv = 1'b0;
      check("bi_addr", addr, 64'h4000);

      // Reset mid-WAIT, late response while IDLE is ignored
      tick();                                     // WAIT
      rst = 1'b1;
      tick();                                     // IDLE
      rst = 1'b0;
      check("mr_req", {63'h0, req}, 64'h0);
      check("mr_inst", {32'h0, inst}, 64'h0);
      iv = 1'b1; idata = 32'hDEAD_BEEF;
      tick();                                     // IDLE -> ISSUE
      iv = 1'b0;
      check("mr_ivld", {63'h0, ivld}, 64'h0);
      check("mr_req2", {63'h0, req}, 64'h1);
      check("mr_addr", addr, 64'h0);
      tick();                                     // WAIT
      check("mr_wait_ivld", {63'h0, ivld}, 64'h0);
      iv = 1'b1; idata = 32'h1234_5678;
      tick();                                     // FULL
      iv = 1'b0;
      check("mr_inst2", {32'h0, inst}, 64'h0000_0000_1234_5678);
      check("mr_ipc2", ipc, 64'h0);

      // pc wrap-around instance
      tick();                                     // reset edge for u_dut_w
      rst_w = 1'b0;
      tick();                                     // ISSUE
      check("wr_addr", addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();                                     // WAIT
      iv_w = 1'b1; idata_w = 32'h5555_0006;
      tick();                                     // FULL
      iv_w = 1'b0;
      check("wr_ivld", {63'h0, ivld_w}, 64'h1);
      check("wr_ipc", ipc_w, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wr_inst", {32'h0, inst_w}, 64'h0000_0000_5555_0006);
      tick();                                     // ISSUE
      check("wr_req", {63'h0, req_w}, 64'h1);
      check("wr_next_addr", addr_w, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
